// File: rtl/apb_reg_responder.sv
// APB completer with a small register bank: control, sticky status, event counter,
// scratch registers and a constant ID. Fixed two-cycle transfers; errors reported via STATUS.
module apb_reg_responder #(
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    // Handshake: a transfer is one SETUP cycle (PSEL=1, PENABLE=0) followed by exactly one
    // ACCESS cycle (PSEL=1, PENABLE=1) with PADDR/PWRITE held; there is no wait state.
    state_t      state, state_next;
    logic [7:0]  addr_q;
    logic        write_q;
    logic        cnt_en, irq_en, ovf, perr;
    logic [7:0]  ill_cnt;
    logic [31:0] count;
    logic [31:0] scratch [NUM_SCRATCH];

    logic                   hit_ctrl, hit_status, hit_count, hit_id;
    logic [NUM_SCRATCH-1:0] hit_scr;
    logic [31:0]            rd_val;
    logic                   rd_ok, wr_ok;
    logic                   setup_ev, access_ev, perr_ev, ill_ev, wr_commit, cnt_clr, wrap;

    assign dbg_state = state;

    // Address decode works on the live PADDR: at the ACCESS edge it equals the captured one.
    always_comb begin
        hit_ctrl   = 1'b0;
        hit_status = 1'b0;
        hit_count  = 1'b0;
        hit_id     = 1'b0;
        hit_scr    = '0;
        rd_val     = '0;
        if (PADDR[1:0] == 2'b00) begin
            case (PADDR[7:2])
                6'd0: begin
                    hit_ctrl = 1'b1;
                    rd_val   = {29'd0, irq_en, 1'b0, cnt_en};
                end
                6'd1: begin
                    hit_status = 1'b1;
                    rd_val     = {16'd0, ill_cnt, 6'd0, perr, ovf};
                end
                6'd2: begin
                    hit_count = 1'b1;
                    rd_val    = count;
                end
                6'd3: begin
                    hit_id = 1'b1;
                    rd_val = ID_VALUE;
                end
                default: begin
                    for (int i = 0; i < NUM_SCRATCH; i++) begin
                        if (PADDR[7:2] == 6'(4 + i)) begin
                            hit_scr[i] = 1'b1;
                            rd_val     = scratch[i];
                        end
                    end
                end
            endcase
        end
    end

    assign rd_ok = hit_ctrl | hit_status | hit_count | hit_id | (|hit_scr);
    assign wr_ok = hit_ctrl | hit_status | (|hit_scr);

    always_comb begin
        state_next = state;
        setup_ev   = 1'b0;
        access_ev  = 1'b0;
        perr_ev    = 1'b0;
        case (state)
            IDLE: begin
                if (PENABLE) begin
                    perr_ev = 1'b1;
                end else if (PSEL) begin
                    setup_ev   = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (!PSEL) begin
                    perr_ev    = 1'b1;
                    state_next = IDLE;
                end else if (PENABLE) begin
                    if (PADDR == addr_q && PWRITE == write_q) begin
                        access_ev  = 1'b1;
                        state_next = ACCESS;
                    end else begin
                        perr_ev    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    setup_ev = 1'b1;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (!PENABLE) begin
                    setup_ev   = 1'b1;
                    state_next = SETUP;
                end else begin
                    // A second ACCESS with no SETUP in between is an enable without a setup.
                    perr_ev    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_commit = access_ev & PWRITE & wr_ok;
    assign ill_ev    = access_ev & (PWRITE ? ~wr_ok : ~rd_ok);
    assign cnt_clr   = wr_commit & hit_ctrl & PWDATA[1];
    assign wrap      = cnt_en & (count == 32'hFFFF_FFFF) & ~cnt_clr;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            PRDATA  <= '0;
            irq     <= 1'b0;
            cnt_en  <= 1'b0;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
            perr    <= 1'b0;
            ill_cnt <= '0;
            count   <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            state <= state_next;
            if (setup_ev) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                PRDATA  <= PWRITE ? 32'd0 : rd_val;
            end

            if (cnt_clr)     count <= '0;
            else if (cnt_en) count <= count + 32'd1;

            // Hardware set wins over a software clear landing in the same cycle.
            ovf  <= wrap    | (ovf  & ~(wr_commit & hit_status & PWDATA[0]));
            perr <= perr_ev | (perr & ~(wr_commit & hit_status & PWDATA[1]));

            if (ill_ev && ill_cnt != 8'hFF) ill_cnt <= ill_cnt + 8'd1;

            if (wr_commit && hit_ctrl) begin
                cnt_en <= PWDATA[0];
                irq_en <= PWDATA[2];
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_commit && hit_scr[i]) scratch[i] <= PWDATA;
            end

            irq <= ovf & irq_en;
        end
    end

endmodule

// File: tb/tb_apb_reg_responder.sv
// Directed bench for apb_reg_responder: driver tasks push expected PRDATA per transfer,
// a negedge monitor pops and compares during every ACCESS cycle.
module tb_apb_reg_responder;

    localparam int K_NONE = 0, K_IRQ = 1, K_PRD = 2, K_TMO = 3, K_DRAIN = 4;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        irq;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    int          req_kind = K_NONE;
    logic [31:0] req_exp;
    string       req_name;

    apb_reg_responder dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .irq(irq), .dbg_state(dbg_state)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that compares.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && !PRESET) begin
            if (exp_q.size() == 0) check("sb_underflow", PRDATA, 32'hxxxx_xxxx);
            else check(name_q.pop_front(), PRDATA, exp_q.pop_front());
        end
        case (req_kind)
            K_IRQ:   check(req_name, {31'd0, irq}, req_exp);
            K_PRD:   check(req_name, PRDATA, req_exp);
            K_TMO:   check(req_name, 32'd0, 32'd1);
            K_DRAIN: check(req_name, exp_q.size(), 32'd0);
            default: ;
        endcase
    end

    // All driver tasks start and end at posedge+1.
    task automatic req(input int kind, input logic [31:0] exp, input string nm);
        req_kind = kind; req_exp = exp; req_name = nm;
        @(negedge PCLK); #1 req_kind = K_NONE;
        @(posedge PCLK); #1;
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    task automatic push(input logic [31:0] exp, input string nm);
        exp_q.push_back(exp); name_q.push_back(nm);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        push(32'd0, "wr_prdata_clr");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        push(exp, nm);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a; PWDATA = 32'h0BAD_F00D;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic do_reset(input int n);
        PRESET = 1'b1;
        idle(n);
        PRESET = 1'b0;
    endtask

    initial begin : main
        bit seen;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        req(K_PRD, 32'd0, "rst_prdata");
        req(K_IRQ, 32'd0, "rst_irq");
        PRESET = 1'b0;
        idle(1);

        // ID and STATUS after reset
        rd(8'h0C, 32'hA9B0_0001, "id");
        rd(8'h04, 32'h0, "status_rst");
        idle(1);

        // Scratch write then back-to-back read
        wr(8'h14, 32'hDEAD_BEEF);
        rd(8'h14, 32'hDEAD_BEEF, "scr1_b2b");
        rd(8'h10, 32'h0, "scr0_zero");
        idle(1);

        // Counter run: enabled at the commit edge, 10 increments before the capture edge
        wr(8'h00, 32'h5);
        idle(10);
        rd(8'h08, 32'd10, "count_run");
        wr(8'h00, 32'h2);
        rd(8'h08, 32'd0, "count_clr");
        rd(8'h00, 32'd0, "ctrl_selfclr");
        idle(1);

        // Wrap: preload the counter near all-ones, then watch OVF and the irq lag
        wr(8'h00, 32'h5);
        force dut.count = 32'hFFFF_FFF0;
        idle(2);
        release dut.count;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge PCLK); #1;
            if (dut.ovf) seen = 1'b1;
        end
        if (!seen) req(K_TMO, 32'd0, "wrap_timeout");
        else begin
            req(K_IRQ, 32'd0, "irq_lag");
            req(K_IRQ, 32'd1, "irq_set");
        end
        rd(8'h04, 32'h1, "status_ovf");
        wr(8'h04, 32'h1);
        idle(2);
        req(K_IRQ, 32'd0, "irq_clr");
        rd(8'h04, 32'h0, "status_w1c");
        wr(8'h00, 32'h2);
        idle(1);

        // Illegal accesses
        wr(8'h08, 32'h1234_5678);
        rd(8'h03, 32'h0, "ill_unaligned");
        rd(8'hF0, 32'h0, "ill_unmapped");
        rd(8'h08, 32'h0, "count_kept");
        rd(8'h04, 32'h0000_0300, "ill_cnt3");
        for (int i = 0; i < 300; i++) rd(8'hF0, 32'h0, "ill_loop");
        rd(8'h04, 32'h0000_FF00, "ill_sat");
        idle(1);

        // Protocol violation: PENABLE with no SETUP
        do_reset(2);
        push(32'd0, "perr_idle_prd");
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h18; PWDATA = 32'h1111_1111;
        @(posedge PCLK); #1;
        idle(1);
        rd(8'h18, 32'h0, "perr_idle_nowr");
        rd(8'h04, 32'h2, "perr_idle");
        wr(8'h04, 32'h2);
        rd(8'h04, 32'h0, "perr_w1c");
        idle(1);

        // Protocol violation: PADDR changes between SETUP and ACCESS
        push(32'd0, "perr_addr_prd");
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h18; PWDATA = 32'h2222_2222;
        @(posedge PCLK); #1 PENABLE = 1'b1; PADDR = 8'h1C;
        @(posedge PCLK); #1;
        idle(1);
        rd(8'h18, 32'h0, "perr_addr_nowr18");
        rd(8'h1C, 32'h0, "perr_addr_nowr1c");
        rd(8'h04, 32'h2, "perr_addr");
        wr(8'h04, 32'h2);
        idle(1);

        // Protocol violation: reset lands on the SETUP cycle of a write
        PRESET = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h5555_5555;
        @(posedge PCLK); #1 PRESET = 1'b0; PENABLE = 1'b1;
        push(32'd0, "perr_rst_prd");
        @(posedge PCLK); #1;
        idle(1);
        rd(8'h10, 32'h0, "perr_rst_nowr");
        rd(8'h04, 32'h2, "perr_rst");
        idle(2);

        req(K_DRAIN, 32'd0, "sb_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_reg_responder.md
Name: apb_reg_responder

Overview:
- APB completer (responder) that answers transfers issued by the team's APB driver on the 8-bit address / 32-bit data bus.
- Holds a small register bank: control, sticky status, an enable-gated 32-bit event counter, scratch registers and a constant ID.
- Tracks the APB phase sequence and flags protocol violations.
- The bus carries no PREADY/PSLVERR, so every transfer completes in exactly two cycles (SETUP, ACCESS). Errors are reported through STATUS only.

Parameters:
- NUM_SCRATCH, 4, number of 32-bit RW scratch registers at 0x10 + 4*i (1..8).
- ID_VALUE, 32'hA9B0_0001, constant returned by the ID register.

Ports:
- PCLK  input  1  bus clock; all state changes on posedge.
- PRESET  input  1  synchronous reset, active-high.
- PSEL  input  1  responder select.
- PENABLE  input  1  ACCESS-phase qualifier.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  8  byte address; word-aligned registers.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data, registered, valid throughout ACCESS.
- irq  output  1  registered level interrupt = STATUS.OVF & CTRL.IRQ_EN.

Behaviour:
- Reset: clock and reset are decided as one clock, synchronous active-high reset. While PRESET is high at a posedge, all of the following take effect:
  - PRDATA=0, irq=0, CTRL=0, STATUS=0, COUNT=0, all scratch=0, FSM=IDLE.
  - Any transfer in flight is dropped; no write commits.
- FSM states:
  - IDLE: PSEL=0.
  - SETUP: first cycle with PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Transitions:
  - IDLE->SETUP on PSEL&!PENABLE.
  - SETUP->ACCESS on PSEL&PENABLE.
  - ACCESS->SETUP on PSEL&!PENABLE (back-to-back transfer).
  - ACCESS->IDLE on !PSEL.
- SETUP edge: PADDR and PWRITE are captured. For reads, PRDATA is loaded with the addressed register value at this same edge, so it is stable for the whole ACCESS cycle.
- PRDATA hold/clear: PRDATA holds its value after ACCESS and is cleared to 0 on the next SETUP of a write.
- Write commit: happens at the posedge ending ACCESS (PSEL&PENABLE&PWRITE sampled), using PWDATA sampled at that edge.
- Protocol violations set STATUS.PERR (sticky) and the transfer is ignored (no write, PRDATA unchanged). Violations are:
  - PENABLE=1 while in IDLE.
  - PSEL&PENABLE seen in SETUP with PADDR or PWRITE different from the captured values.
  - PSEL dropped in SETUP (SETUP->IDLE).
- Register map (offset, access, fields):
  - 0x00 CTRL RW: [0] CNT_EN, [1] CNT_CLR (self-clearing, always reads 0), [2] IRQ_EN; other bits read 0.
  - 0x04 STATUS: [0] OVF (W1C), [1] PERR (W1C), [15:8] ILL_CNT (RO, saturating at 255), others 0.
  - 0x08 COUNT RO: +1 per cycle while CNT_EN=1; wraps 0xFFFF_FFFF->0 and sets OVF on the wrap.
  - 0x0C ID RO: ID_VALUE.
  - 0x10.. SCRATCH[i] RW.
- Illegal access: unmapped address, PADDR[1:0]!=0, or a write to an RO register.
  - Read returns 0; write is ignored.
  - ILL_CNT increments once per completed ACCESS and saturates at 255.
- Simultaneous events:
  - CNT_CLR write beats increment in the same cycle: COUNT=0, no OVF.
  - OVF set beats a W1C of OVF in the same cycle.
  - PERR set beats a W1C of PERR.
  - A COUNT read captures the pre-increment value at the SETUP edge.
- irq: registered, so it follows OVF/IRQ_EN changes one cycle later.

Test Plan:
- Reset then read ID at 0x0C -> PRDATA=0xA9B0_0001 during ACCESS; read STATUS -> 0x0000_0000.
- Write 0xDEAD_BEEF to 0x14, read 0x14 back-to-back (ACCESS->SETUP with no IDLE) -> 0xDEAD_BEEF; scratch at 0x10 still 0.
- Write CTRL=0x5, 10 idle cycles, then read COUNT -> value in 10..14 (exact per model); write CTRL=0x2 -> COUNT=0 the next cycle and CTRL reads 0x0.
- Force COUNT near wrap: enable and wait until it reaches 0xFFFF_FFFF -> wraps to 0, OVF=1, irq=1 one cycle later; W1C 0x1 to STATUS -> OVF=0, irq=0.
- Write to 0x08, then read from 0x03 and 0xF0 -> reads return 0, COUNT unaffected, ILL_CNT=3; 300 illegal accesses -> ILL_CNT=255.
- Each of the following -> PERR=1 and no write commits: PENABLE asserted without a prior SETUP; PADDR changed between SETUP and ACCESS; PRESET asserted in the SETUP cycle of a write.
